// File: rtl/montgomery_reduce_lanes_pkg.sv
// montgomery_reduce_lanes_pkg: modulus constants, mode enum and a reference reduction.
package montgomery_reduce_lanes_pkg;
    typedef enum logic {MODE_DIL = 1'b0, MODE_KYB = 1'b1} mont_mode_e;
    localparam int          KMAX  = 32;
    localparam int          K0    = 32;
    localparam logic [31:0] Q0    = 32'd8380417;
    localparam logic [31:0] QINV0 = 32'd4236238847;
    localparam int          K1    = 16;
    localparam logic [31:0] Q1    = 32'd3329;
    localparam logic [31:0] QINV1 = 32'd3327;

    function automatic logic [31:0] mont_ref(input logic [63:0] x, input mont_mode_e mode);
        logic [31:0] q;
        logic [31:0] m;
        logic [63:0] p;
        logic [64:0] s;
        int k;
        k = (mode == MODE_KYB) ? K1 : K0;
        q = (mode == MODE_KYB) ? Q1 : Q0;
        p = 64'(x[31:0]) * 64'((mode == MODE_KYB) ? QINV1 : QINV0);
        m = (mode == MODE_KYB) ? {16'b0, p[15:0]} : p[31:0];
        if (x >= (64'(q) << k)) return 32'd0;
        s = (65'(x) + 65'(m) * 65'(q)) >> k;
        return (s >= 65'(q)) ? 32'(s - 65'(q)) : s[31:0];
    endfunction
endpackage

// File: rtl/montgomery_reduce_lanes_lane.sv
// montgomery_lane: one lane of the three-stage Montgomery reduction datapath.
module montgomery_lane
    import montgomery_reduce_lanes_pkg::*;
#(
    parameter int X_W = 64,
    parameter int Q_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  mont_mode_e     mode_s0_i,
    input  mont_mode_e     mode_s1_i,
    input  mont_mode_e     mode_s2_i,
    input  logic [X_W-1:0] x_i,
    output logic [Q_W-1:0] r_o,
    output logic           err_o
);
    logic [X_W-1:0]    x1_q;
    logic [KMAX-1:0]   m1_d, m1_q;
    logic              err1_d, err1_q, err2_q, err3_q;
    logic [Q_W:0]      t2_d, t2_q;
    logic [Q_W-1:0]    r3_d, r3_q;
    logic [2*KMAX-1:0] p0;
    logic [X_W:0]      sum;
    logic [KMAX-1:0]   q1, q2;

    always_comb begin
        p0     = 64'(x_i[KMAX-1:0]) * 64'((mode_s0_i == MODE_KYB) ? QINV1 : QINV0);
        m1_d   = (mode_s0_i == MODE_KYB) ? {{(KMAX-K1){1'b0}}, p0[K1-1:0]} : p0[K0-1:0];
        err1_d = x_i >= ((mode_s0_i == MODE_KYB) ? X_W'(Q1) << K1 : X_W'(Q0) << K0);
        q1     = (mode_s1_i == MODE_KYB) ? Q1 : Q0;
        // x + m*q is exactly divisible by 2^K, so the shift drops only zeros
        sum    = (X_W+1)'(x1_q) + (X_W+1)'(64'(m1_q) * 64'(q1));
        t2_d   = (Q_W+1)'((mode_s1_i == MODE_KYB) ? sum >> K1 : sum >> K0);
        q2     = (mode_s2_i == MODE_KYB) ? Q1 : Q0;
        r3_d   = err2_q ? '0 : Q_W'((t2_q >= (Q_W+1)'(q2)) ? t2_q - (Q_W+1)'(q2) : t2_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x1_q   <= '0;
            m1_q   <= '0;
            err1_q <= 1'b0;
            t2_q   <= '0;
            err2_q <= 1'b0;
            r3_q   <= '0;
            err3_q <= 1'b0;
        end else if (en_i) begin
            x1_q   <= x_i;
            m1_q   <= m1_d;
            err1_q <= err1_d;
            t2_q   <= t2_d;
            err2_q <= err1_q;
            r3_q   <= r3_d;
            err3_q <= err2_q;
        end
    end

    assign r_o   = r3_q;
    assign err_o = err3_q;
endmodule

// File: rtl/montgomery_reduce_lanes.sv
// montgomery_reduce_lanes: multi-lane dual-modulus Montgomery reducer with a
// three-stage valid/ready pipeline carrying mode and tag alongside the lanes.
module montgomery_reduce_lanes
    import montgomery_reduce_lanes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int X_W   = 64,
    parameter int Q_W   = 32,
    parameter int TAG_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_mode_i,
    input  logic [TAG_W-1:0]       in_tag_i,
    input  logic [LANES*X_W-1:0]   in_x_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_mode_o,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic [LANES*Q_W-1:0]   out_r_o,
    output logic [LANES-1:0]       out_err_o,
    output logic                   busy_o
);
    logic                  en;
    logic [2:0]            valid_d, valid_q;
    logic [2:0]            mode_q;
    logic [2:0][TAG_W-1:0] tag_q;

    assign en         = !valid_q[2] || out_ready_i;
    assign in_ready_o = en;

    always_comb begin
        valid_d = en ? {valid_q[1:0], in_valid_i} : valid_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (en) begin
                mode_q <= {mode_q[1:0], in_mode_i};
                tag_q  <= {tag_q[1:0], in_tag_i};
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        montgomery_lane #(.X_W(X_W), .Q_W(Q_W)) u_lane (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en),
            .mode_s0_i (mont_mode_e'(in_mode_i)),
            .mode_s1_i (mont_mode_e'(mode_q[0])),
            .mode_s2_i (mont_mode_e'(mode_q[1])),
            .x_i       (in_x_i[l*X_W +: X_W]),
            .r_o       (out_r_o[l*Q_W +: Q_W]),
            .err_o     (out_err_o[l])
        );
    end

    assign out_valid_o = valid_q[2];
    assign out_mode_o  = mode_q[2];
    assign out_tag_o   = tag_q[2];
    assign busy_o      = |valid_q;
endmodule

// File: tb/tb_montgomery_reduce_lanes.sv
// tb_montgomery_reduce_lanes: directed checks of reduction values, range errors,
// latency, backpressure ordering, mixed modes and mid-flight reset.
module tb_montgomery_reduce_lanes;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready_o;
    logic         in_mode = 1'b0;
    logic [7:0]   in_tag = '0;
    logic [255:0] in_x = '0;
    logic         out_valid_o;
    logic         out_ready = 1'b1;
    logic         out_mode_o;
    logic [7:0]   out_tag_o;
    logic [127:0] out_r_o;
    logic [3:0]   out_err_o;
    logic         busy_o;
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_fail = 0;

    montgomery_reduce_lanes dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .in_mode_i(in_mode), .in_tag_i(in_tag), .in_x_i(in_x), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready), .out_mode_o(out_mode_o), .out_tag_o(out_tag_o),
        .out_r_o(out_r_o), .out_err_o(out_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Independent model: reduce mod q, then halve mod q K times (multiply by 2^-K)
    function automatic logic [31:0] ref_r(input logic [63:0] x, input logic mode);
        logic [63:0] q;
        logic [63:0] a;
        int k;
        q = mode ? 64'd3329 : 64'd8380417;
        k = mode ? 16 : 32;
        a = x % q;
        for (int i = 0; i < k; i++) a = a[0] ? (a + q) >> 1 : a >> 1;
        return (x >= (q << k)) ? 32'd0 : a[31:0];
    endfunction

    function automatic logic [127:0] exp_r(input logic [255:0] xv, input logic mode);
        logic [127:0] res;
        for (int l = 0; l < 4; l++) res[l*32 +: 32] = ref_r(xv[l*64 +: 64], mode);
        return res;
    endfunction

    function automatic logic [255:0] bp_x(input int b);
        logic [255:0] v;
        for (int l = 0; l < 4; l++) v[l*64 +: 64] = 64'(b * 1000003 + l + 1) * 64'd987654321;
        return v;
    endfunction

    function automatic logic [255:0] alt_x(input int b);
        logic [255:0] v;
        for (int l = 0; l < 4; l++)
            v[l*64 +: 64] = b[0] ? 64'((b * 4 + l) * 5000003) : 64'(b * 4 + l) * 64'd987654321987;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string nm, input logic mode, input logic [7:0] tag,
                            input logic [255:0] xv, input logic [127:0] er, input logic [3:0] ee);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = mode;
        in_tag = tag;
        in_x = xv;
        step();
        in_valid = 1'b0;
        chk({nm, "_lat1"}, 128'(out_valid_o), 128'd0);
        step();
        chk({nm, "_lat2"}, 128'(out_valid_o), 128'd0);
        step();
        chk({nm, "_valid"}, 128'(out_valid_o), 128'd1);
        chk({nm, "_mode"}, 128'(out_mode_o), 128'(mode));
        chk({nm, "_tag"}, 128'(out_tag_o), 128'(tag));
        chk({nm, "_r"}, out_r_o, er);
        chk({nm, "_err"}, 128'(out_err_o), 128'(ee));
        step();
    endtask

    initial begin
        logic [255:0] xv;
        int sent;
        int rcv;
        logic acc;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 128'(out_valid_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_ready", 128'(in_ready_o), 128'd1);
        chk("rst_r", out_r_o, 128'd0);
        chk("rst_err", 128'(out_err_o), 128'd0);
        chk("rst_tag", 128'(out_tag_o), 128'd0);

        send_one("m0_basic", 1'b0, 8'h01,
                 {64'd8380417, 64'd0, 64'd5 << 32, 64'd1 << 32},
                 {32'd0, 32'd0, 32'd5, 32'd1}, 4'b0000);

        xv = {64'd0, (64'd3329 << 16) - 64'd1, 64'd3 << 16, 64'd1 << 16};
        send_one("m1_basic", 1'b1, 8'h02, xv,
                 {32'd0, ref_r(xv[191:128], 1'b1), 32'd3, 32'd1}, 4'b0000);

        xv = {64'd1, 64'd0, (64'd8380417 << 32) - 64'd1, 64'd8380417 << 32};
        send_one("m0_range", 1'b0, 8'h03, xv,
                 {ref_r(64'd1, 1'b0), 32'd0, ref_r(xv[127:64], 1'b0), 32'd0}, 4'b0001);

        xv = {64'd0, (64'd3329 << 16) - 64'd1, 64'd3329 << 16, 64'd1 << 40};
        send_one("m1_range", 1'b1, 8'h04, xv,
                 {32'd0, ref_r(xv[191:128], 1'b1), 32'd0, 32'd0}, 4'b0011);

        sent = 0;
        rcv = 0;
        for (int c = 0; c < 400 && rcv < 16; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 16);
            in_mode = 1'b0;
            in_tag = 8'(sent);
            in_x = bp_x(sent);
            #1;
            acc = in_valid && in_ready_o;
            if (out_valid_o) begin
                chk("bp_tag", 128'(out_tag_o), 128'(rcv));
                chk("bp_r", out_r_o, exp_r(bp_x(rcv), 1'b0));
                if (out_ready) rcv++;
            end
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", 128'(sent), 128'd16);
        chk("bp_rcv", 128'(rcv), 128'd16);
        chk("bp_nodup", 128'(out_valid_o), 128'd0);
        step();

        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            in_mode = c[0];
            in_tag = 8'(8'h40 + c);
            in_x = alt_x(c);
            step();
            if (c >= 2) begin
                chk("alt_valid", 128'(out_valid_o), 128'd1);
                chk("alt_mode", 128'(out_mode_o), 128'((c - 2) % 2));
                chk("alt_tag", 128'(out_tag_o), 128'(8'h40 + c - 2));
                chk("alt_r", out_r_o, exp_r(alt_x(c - 2), 1'((c - 2) % 2)));
            end
        end
        in_valid = 1'b0;
        step();
        chk("alt_drain", 128'(out_valid_o), 128'd0);

        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_mode = 1'b0;
            in_tag = 8'(8'h80 + c);
            in_x = bp_x(c);
            step();
        end
        chk("pre_rst_busy", 128'(busy_o), 128'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 128'(out_valid_o), 128'd0);
        chk("mid_rst_busy", 128'(busy_o), 128'd0);
        chk("mid_rst_r", out_r_o, 128'd0);
        chk("mid_rst_tag", 128'(out_tag_o), 128'd0);
        send_one("post_rst", 1'b0, 8'h99, {64'd0, 64'd0, 64'd9 << 32, 64'd7 << 32},
                 {32'd0, 32'd0, 32'd9, 32'd7}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
